axis_ss_fifo: RTL and testbench
===============================

AXIS_SS_FIFO -- requirements
Module: axis_ss_fifo

Interface
REQ-001 Parameter pDATA_WIDTH SHALL default 32; tdata width.
REQ-002 Parameter pDEPTH SHALL default 4; entry count, power of two, 2..16.
REQ-003 ASCLK  in  1  sole clock; all state updates on rising edge.
REQ-004 ARESET_N  in  1  synchronous, active-low reset.
REQ-005 is_tdata  in  pDATA_WIDTH  ingress beat data.
REQ-006 is_tid  in  3  ingress stream id.
REQ-007 is_tkeep  in  1  ingress keep.
REQ-008 is_tlast  in  1  ingress end-of-packet.
REQ-009 is_tstrb  in  4  ingress byte strobes.
REQ-010 is_tvalid  in  1  ingress beat valid.
REQ-011 is_tready  out  1  FIFO can accept a beat.
REQ-012 a_ss_tdata/a_ss_tid/a_ss_tkeep/a_ss_tlast/a_ss_tstrb  out  pDATA_WIDTH/3/1/1/4  head-entry fields toward AXIS slave demux.
REQ-013 a_ss_tvalid  out  1  head entry valid.
REQ-014 a_ss_tready  in  1  demux accepts head entry.
REQ-015 fifo_count  out  clog2(pDEPTH)+1  current occupancy.
REQ-016 pkt_cnt  out  16  egress packets completed (see Configuration).

Function
REQ-017 Push SHALL occur on a cycle with is_tvalid=1 and is_tready=1; all five sideband/data fields stored as one entry.
REQ-018 Pop SHALL occur on a cycle with a_ss_tvalid=1 and a_ss_tready=1.
REQ-019 is_tready SHALL be 1 iff fifo_count < pDEPTH, decoded from registered count only (no combinational path from a_ss_tready).
REQ-020 a_ss_tvalid SHALL be 1 iff fifo_count != 0; a_ss_* fields SHALL reflect entry at read pointer.
REQ-021 Latency: beat pushed at edge N SHALL present a_ss_tvalid=1 with its data after edge N, i.e. first visible cycle N+1; no bypass when empty.
REQ-022 Ordering SHALL be strict FIFO; no reorder, drop, or merge of beats; tlast/tid carried unchanged.
REQ-023 Push and pop in the same cycle SHALL leave fifo_count unchanged and advance both pointers; sustained throughput one beat/cycle.
REQ-024 When full, is_tvalid SHALL be ignored (no overwrite); when empty, a_ss_tready SHALL be ignored (no underflow, count stays 0).
REQ-025 Read/write pointers SHALL wrap modulo pDEPTH; fifo_count SHALL never exceed pDEPTH.
REQ-026 Once a_ss_tvalid=1, head fields SHALL stay stable until popped (AXIS rule).

Reset
REQ-027 ARESET_N=0 at an edge SHALL clear pointers and fifo_count to 0, discarding stored beats, including mid-packet.
REQ-028 During reset and the first cycle after: a_ss_tvalid=0, is_tready=0 during reset, is_tready=1 after release, pkt_cnt=0.
REQ-029 Storage array SHALL not require reset; a_ss_tdata value is don't-care while a_ss_tvalid=0.

Configuration
REQ-030 Macro AXIS_SS_FIFO_PKTCNT_EN defined: pkt_cnt SHALL increment by 1 on each pop with a_ss_tlast=1, wrapping 0xFFFF->0x0000.
REQ-031 Macro undefined: pkt_cnt SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-032 Reset, then push 3 beats 0x11,0x22,0x33 with a_ss_tready=0 -> fifo_count=3, a_ss_tdata=0x11 stable, is_tready=1.
REQ-033 Push 4 beats (pDEPTH=4), a_ss_tready=0, hold is_tvalid=1 with 0x55 -> is_tready=0, count=4, 0x55 not stored; then pop 4 -> order preserved, count=0, a_ss_tvalid=0.
REQ-034 Continuous is_tvalid=1 and a_ss_tready=1 for 20 beats -> one beat/cycle egress, 1-cycle latency, count stays 1.
REQ-035 Pop with count=0 (a_ss_tready=1) -> count stays 0, pointers unchanged.
REQ-036 With AXIS_SS_FIFO_PKTCNT_EN, send 3 packets of 2 beats, tid=5 -> pkt_cnt=3, egress tid=5 each beat; without macro -> pkt_cnt=0.
REQ-037 Assert ARESET_N=0 with 2 beats stored mid-packet -> next cycle count=0, a_ss_tvalid=0; subsequent beat 0xAA emerges first.

Source files
------------

// File: rtl/axis_ss_fifo.sv
// Single-clock AXI-Stream FIFO feeding the slave demux; registered-count flow control, no empty bypass.
// Optional egress packet counter enabled by defining AXIS_SS_FIFO_PKTCNT_EN.
module axis_ss_fifo #(
    parameter int pDATA_WIDTH = 32,
    parameter int pDEPTH      = 4
) (
    input  logic                     ASCLK,
    input  logic                     ARESET_N,
    input  logic [pDATA_WIDTH-1:0]   is_tdata,
    input  logic [2:0]               is_tid,
    input  logic                     is_tkeep,
    input  logic                     is_tlast,
    input  logic [3:0]               is_tstrb,
    input  logic                     is_tvalid,
    output logic                     is_tready,
    output logic [pDATA_WIDTH-1:0]   a_ss_tdata,
    output logic [2:0]               a_ss_tid,
    output logic                     a_ss_tkeep,
    output logic                     a_ss_tlast,
    output logic [3:0]               a_ss_tstrb,
    output logic                     a_ss_tvalid,
    input  logic                     a_ss_tready,
    output logic [$clog2(pDEPTH):0]  fifo_count,
    output logic [15:0]              pkt_cnt
);
    localparam int AW = $clog2(pDEPTH);

    typedef struct packed {
        logic [pDATA_WIDTH-1:0] data;
        logic [2:0]             tid;
        logic                   keep;
        logic                   last;
        logic [3:0]             strb;
    } ent_t;

    ent_t          mem [pDEPTH];
    ent_t          wr_ent;
    ent_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Depth is a power of two, so the count MSB is exactly the full flag.
    assign is_tready   = ARESET_N & ~fifo_count[AW];
    assign a_ss_tvalid = |fifo_count;
    assign push        = is_tvalid & is_tready;
    assign pop         = a_ss_tvalid & a_ss_tready;

    assign wr_ent = '{data: is_tdata, tid: is_tid, keep: is_tkeep,
                      last: is_tlast, strb: is_tstrb};
    assign head   = mem[rd_ptr];

    assign a_ss_tdata = head.data;
    assign a_ss_tid   = head.tid;
    assign a_ss_tkeep = head.keep;
    assign a_ss_tlast = head.last;
    assign a_ss_tstrb = head.strb;

    always_ff @(posedge ASCLK) begin
        if (push) mem[wr_ptr] <= wr_ent;
    end

    always_ff @(posedge ASCLK) begin
        if (!ARESET_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef AXIS_SS_FIFO_PKTCNT_EN
    always_ff @(posedge ASCLK) begin
        if (!ARESET_N)            pkt_cnt <= '0;
        else if (pop && head.last) pkt_cnt <= pkt_cnt + 16'd1;
    end
`else
    assign pkt_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_axis_ss_fifo.sv
// Randomized + directed bench for axis_ss_fifo against a queue-based reference model.
module tb_axis_ss_fifo;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          ASCLK = 1'b0;
    logic          ARESET_N;
    logic [DW-1:0] is_tdata;
    logic [2:0]    is_tid;
    logic          is_tkeep, is_tlast, is_tvalid, is_tready;
    logic [3:0]    is_tstrb;
    logic [DW-1:0] a_ss_tdata;
    logic [2:0]    a_ss_tid;
    logic          a_ss_tkeep, a_ss_tlast, a_ss_tvalid, a_ss_tready;
    logic [3:0]    a_ss_tstrb;
    logic [2:0]    fifo_count;
    logic [15:0]   pkt_cnt;

    axis_ss_fifo #(.pDATA_WIDTH(DW), .pDEPTH(DEPTH)) dut (
        .ASCLK(ASCLK), .ARESET_N(ARESET_N),
        .is_tdata(is_tdata), .is_tid(is_tid), .is_tkeep(is_tkeep),
        .is_tlast(is_tlast), .is_tstrb(is_tstrb), .is_tvalid(is_tvalid),
        .is_tready(is_tready),
        .a_ss_tdata(a_ss_tdata), .a_ss_tid(a_ss_tid), .a_ss_tkeep(a_ss_tkeep),
        .a_ss_tlast(a_ss_tlast), .a_ss_tstrb(a_ss_tstrb),
        .a_ss_tvalid(a_ss_tvalid), .a_ss_tready(a_ss_tready),
        .fifo_count(fifo_count), .pkt_cnt(pkt_cnt)
    );

    always #5 ASCLK = ~ASCLK;

    typedef struct {
        logic [DW-1:0] d;
        logic [2:0]    id;
        logic          k;
        logic          l;
        logic [3:0]    s;
    } ent_t;

    ent_t        q[$];
    int unsigned exp_pk = 0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output with the model; outputs sampled mid-cycle.
    task automatic chk_all();
        chk("count", 64'(fifo_count), 64'(q.size()));
        chk("tvalid", 64'(a_ss_tvalid), 64'(q.size() != 0));
        chk("tready", 64'(is_tready), 64'(q.size() < DEPTH));
`ifdef AXIS_SS_FIFO_PKTCNT_EN
        chk("pkt_cnt", 64'(pkt_cnt), 64'(exp_pk & 16'hFFFF));
`else
        chk("pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif
        if (q.size() != 0) begin
            chk("tdata", 64'(a_ss_tdata), 64'(q[0].d));
            chk("tid", 64'(a_ss_tid), 64'(q[0].id));
            chk("tkeep", 64'(a_ss_tkeep), 64'(q[0].k));
            chk("tlast", 64'(a_ss_tlast), 64'(q[0].l));
            chk("tstrb", 64'(a_ss_tstrb), 64'(q[0].s));
        end
    endtask

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [2:0] id,
                       input logic l, input logic r);
        ent_t e;
        logic do_push, do_pop;
        @(negedge ASCLK);
        is_tvalid = v; is_tdata = d; is_tid = id; is_tlast = l;
        is_tkeep = 1'($urandom); is_tstrb = 4'($urandom);
        a_ss_tready = r;
        #1 chk_all();
        e = '{d: d, id: id, k: is_tkeep, l: l, s: is_tstrb};
        do_push = v && (q.size() < DEPTH);
        do_pop  = r && (q.size() != 0);
        @(posedge ASCLK);
        if (do_pop) begin
            if (q[0].l) exp_pk++;
            void'(q.pop_front());
        end
        if (do_push) q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge ASCLK);
        ARESET_N = 1'b0; is_tvalid = 1'b1; a_ss_tready = 1'b1;
        #1 chk("tready_in_rst", 64'(is_tready), 64'd0);
        @(posedge ASCLK);
        q.delete(); exp_pk = 0;
        #1 chk("tvalid_in_rst", 64'(a_ss_tvalid), 64'd0);
        chk("count_in_rst", 64'(fifo_count), 64'd0);
        @(negedge ASCLK);
        ARESET_N = 1'b1; is_tvalid = 1'b0; a_ss_tready = 1'b0;
        #1 chk("tready_after_rst", 64'(is_tready), 64'd1);
        chk("pkt_after_rst", 64'(pkt_cnt), 64'd0);
    endtask

    initial begin
        ARESET_N = 1'b0; is_tvalid = 1'b0; is_tdata = '0; is_tid = '0;
        is_tkeep = 1'b0; is_tlast = 1'b0; is_tstrb = '0; a_ss_tready = 1'b0;
        repeat (2) @(posedge ASCLK);
        do_reset();

        // Three beats held at the head.
        cyc(1, 32'h11, 3'd0, 0, 0);
        cyc(1, 32'h22, 3'd0, 0, 0);
        cyc(1, 32'h33, 3'd0, 0, 0);
        repeat (2) cyc(0, 32'h0, 3'd0, 0, 0);
        chk("cnt3", 64'(fifo_count), 64'd3);
        chk("head11", 64'(a_ss_tdata), 64'h11);

        // Fill, then offer 0x55 while full, then drain.
        cyc(1, 32'h44, 3'd0, 0, 0);
        repeat (3) cyc(1, 32'h55, 3'd0, 0, 0);
        chk("full_tready", 64'(is_tready), 64'd0);
        repeat (5) cyc(0, 32'h0, 3'd0, 0, 1);
        chk("drained", 64'(a_ss_tvalid), 64'd0);

        // Underflow attempt.
        repeat (3) cyc(0, 32'h0, 3'd0, 0, 1);
        chk("empty_cnt", 64'(fifo_count), 64'd0);

        // Streaming: one beat per cycle, count settles at 1.
        for (int i = 0; i < 20; i++) cyc(1, 32'h100 + i, 3'(i), 1'(i % 3 == 2), 1);
        chk("stream_cnt", 64'(fifo_count), 64'd1);
        cyc(0, 32'h0, 3'd0, 0, 1);

        // Three 2-beat packets on tid 5.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            cyc(1, 32'hA0 + p, 3'd5, 0, 1);
            cyc(1, 32'hB0 + p, 3'd5, 1, 1);
        end
        repeat (2) cyc(0, 32'h0, 3'd0, 0, 1);
`ifdef AXIS_SS_FIFO_PKTCNT_EN
        chk("pkt3", 64'(pkt_cnt), 64'd3);
`else
        chk("pkt0", 64'(pkt_cnt), 64'd0);
`endif

        // Reset mid-packet discards stored beats.
        cyc(1, 32'hC1, 3'd2, 0, 0);
        cyc(1, 32'hC2, 3'd2, 0, 0);
        do_reset();
        cyc(1, 32'hAA, 3'd1, 1, 0);
        cyc(0, 32'h0, 3'd0, 0, 0);
        chk("after_rst_head", 64'(a_ss_tdata), 64'hAA);
        cyc(0, 32'h0, 3'd0, 0, 1);

        // Random traffic with biased valid/ready.
        for (int i = 0; i < 2000; i++)
            cyc(1'($urandom_range(0, 99) < 60), $urandom, 3'($urandom),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 99) < 55));
        repeat (6) cyc(0, 32'h0, 3'd0, 0, 1);
        @(negedge ASCLK);
        #1 chk_all();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
